cond_logic: RTL and testbench

Consumer end of the ALU decoder's ALUControl/FlagW interface in the ARMv4 single-cycle datapath. Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against it. Gates PCS/RegW/MemW from the main decoder into PCSrc/RegWrite/MemWrite. Keeps saturating executed/skipped instruction counters for debug.

---
 rtl/arm_pkg.sv | 14 +
 rtl/cond_check.sv | 37 +++
 rtl/cond_logic.sv | 74 +++++++
 tb/tb_cond_logic.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared condition codes, flag indices and FlagW encodings
package arm_pkg;
    typedef enum logic [3:0] {
        EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_t;
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;
    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;
endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV flags
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);
    logic w_n, w_z, w_c, w_v, w_ge;
    assign w_n  = i_flags[N_IDX];
    assign w_z  = i_flags[Z_IDX];
    assign w_c  = i_flags[C_IDX];
    assign w_v  = i_flags[V_IDX];
    assign w_ge = (w_n == w_v);
    // condition table; NV never executes
    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_t'(i_cond))
            EQ: o_cond_ex = w_z;
            NE: o_cond_ex = !w_z;
            CS: o_cond_ex = w_c;
            CC: o_cond_ex = !w_c;
            MI: o_cond_ex = w_n;
            PL: o_cond_ex = !w_n;
            VS: o_cond_ex = w_v;
            VC: o_cond_ex = !w_v;
            HI: o_cond_ex = w_c && !w_z;
            LS: o_cond_ex = !w_c || w_z;
            GE: o_cond_ex = w_ge;
            LT: o_cond_ex = !w_ge;
            GT: o_cond_ex = !w_z && w_ge;
            LE: o_cond_ex = w_z || !w_ge;
            AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register, condition gating and debug counters
module cond_logic
    import arm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec;
    logic [CNT_W-1:0] r_skip;
    logic             w_cond_ex;
    logic             w_commit;

    cond_check u_cond_check (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_commit  = w_cond_ex && InstrValid && !reset;
    assign CondEx    = w_cond_ex;
    assign PCSrc     = PCS && w_commit;
    assign RegWrite  = RegW && w_commit && !NoWrite;
    assign MemWrite  = MemW && w_commit;
    assign Flags     = r_flags;
    assign ExecCount = r_exec;
    assign SkipCount = r_skip;

    // flag register: only executed instructions write, per FlagW half
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_commit) begin
            if (FlagW[1]) begin
                r_flags[N_IDX] <= ALUFlags[N_IDX];
                r_flags[Z_IDX] <= ALUFlags[Z_IDX];
            end
            if (FlagW[0]) begin
                r_flags[C_IDX] <= ALUFlags[C_IDX];
                r_flags[V_IDX] <= ALUFlags[V_IDX];
            end
        end
    end

    // saturating executed/skipped counters for valid instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec <= '0;
            r_skip <= '0;
        end else if (InstrValid) begin
            if (w_cond_ex)
                r_exec <= (&r_exec) ? r_exec : r_exec + 1'b1;
            else
                r_skip <= (&r_skip) ? r_skip : r_skip + 1'b1;
        end
    end
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed scoreboard bench for cond_logic with CNT_W=4
module tb_cond_logic;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       InstrValid = 1'b0;
    logic [3:0] Cond = 4'b0;
    logic [3:0] ALUFlags = 4'b0;
    logic [1:0] FlagW = 2'b0;
    logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags, ExecCount, SkipCount;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] m_flags = 4'b0;
    logic [3:0] m_exec = 4'b0;
    logic [3:0] m_skip = 4'b0;

    cond_logic #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // ARM-style evaluation: base test on Cond[3:1], inverted by Cond[0]
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return c[0] ? ~b : b;
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty obs=%0h", obs);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        assert (obs === e.exp) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] c,
                        input logic [3:0] a, input logic [1:0] fw,
                        input logic p, input logic rw, input logic mw,
                        input logic nw);
        logic ce;
        @(negedge clk);
        reset = r; InstrValid = v; Cond = c; ALUFlags = a; FlagW = fw;
        PCS = p; RegW = rw; MemW = mw; NoWrite = nw;
        #1;
        ce = ref_cond(c, m_flags);
        push("cond_ex", {31'b0, ce});
        push("pcsrc", {31'b0, p & ce & v & ~r});
        push("regwrite", {31'b0, rw & ce & v & ~r & ~nw});
        push("memwrite", {31'b0, mw & ce & v & ~r});
        chk({31'b0, CondEx});
        chk({31'b0, PCSrc});
        chk({31'b0, RegWrite});
        chk({31'b0, MemWrite});
        @(posedge clk);
        if (r) begin
            m_flags = 4'b0; m_exec = 4'b0; m_skip = 4'b0;
        end else if (v) begin
            if (ce) begin
                if (fw[1]) m_flags[3:2] = a[3:2];
                if (fw[0]) m_flags[1:0] = a[1:0];
                if (m_exec != 4'hF) m_exec = m_exec + 4'd1;
            end else if (m_skip != 4'hF) begin
                m_skip = m_skip + 4'd1;
            end
        end
        #1;
        push("flags", {28'b0, m_flags});
        push("exec_count", {28'b0, m_exec});
        push("skip_count", {28'b0, m_skip});
        chk({28'b0, Flags});
        chk({28'b0, ExecCount});
        chk({28'b0, SkipCount});
    endtask

    // set flags with an AL, FlagW=11 instruction
    task automatic set_flags(input logic [3:0] f);
        step(0, 1, 4'b1110, f, 2'b11, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        step(0, 1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 0);
        push("adds_flags", 32'h6); chk({28'b0, Flags});
        push("adds_exec", 32'h1); chk({28'b0, ExecCount});
        set_flags(4'b0000);
        step(0, 1, 4'b0000, 4'b0100, 2'b11, 0, 1, 0, 0);
        push("eq_fail_flags", 32'h0); chk({28'b0, Flags});
        push("eq_fail_skip", 32'h1); chk({28'b0, SkipCount});
        step(0, 1, 4'b0000, 4'b0100, 2'b11, 0, 1, 0, 0);
        set_flags(4'b1111);
        step(0, 1, 4'b1110, 4'b0000, 2'b10, 0, 1, 0, 0);
        push("partial_flags", 32'h3); chk({28'b0, Flags});
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++)
                step(0, 0, 4'(c), 4'(15 - c), 2'b11, 1, 1, 1, 0);
        end
        step(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 1);
        set_flags(4'b1001);
        step(0, 1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0);
        set_flags(4'b1000);
        step(0, 1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0);
        step(0, 0, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 0);
        step(0, 1, 4'b0001, 4'b0101, 2'b11, 1, 1, 1, 0);
        for (int i = 0; i < 20; i++)
            step(0, 1, 4'b1110, 4'(i), 2'(i), 1, 0, 1, 0);
        push("exec_sat", 32'hF); chk({28'b0, ExecCount});
        step(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        push("rst_flags", 32'h0); chk({28'b0, Flags});
        push("rst_exec", 32'h0); chk({28'b0, ExecCount});
        step(0, 1, 4'b0000, 4'b1111, 2'b11, 0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
